// File: rtl/tile_pkg.sv
// Shared types and constants for the tile shuffler.
// LFSR polynomial x^16+x^14+x^13+x^11+1 in Galois form.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    DONE
  } shuf_state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/tile_shuffler_lfsr16.sv
// Free-running 16-bit Galois LFSR with seed load.
// A zero seed is replaced so the register never locks up.
module lfsr16
  import tile_pkg::*;
#(
  parameter logic [15:0] SEED_INIT = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] step;

  assign step = q[0] ? ((q >> 1) ^ LFSR_TAPS)
                     : (q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_INIT;
    end else if (load) begin
      q <= (load_val == 16'h0) ? SEED_INIT
                               : load_val;
    end else begin
      q <= step;
    end
  end

endmodule

// File: rtl/tile_shuffler.sv
// Fisher-Yates tile permutation driven by a 16-bit LFSR.
// One swap per clock; result published as a packed vector.
module tile_shuffler
  import tile_pkg::*;
#(
  parameter int          N_TILES   = 24,
  parameter logic [15:0] SEED_INIT = DEFAULT_SEED
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             seed_load,
  input  logic [15:0]                      seed_in,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             order_valid,
  output logic [N_TILES*$clog2(N_TILES)-1:0] order
);

  localparam int IDX_W = $clog2(N_TILES);
  localparam int VEC_W = N_TILES * IDX_W;

  shuf_state_t       state;
  logic [15:0]       lfsr_q;
  logic [IDX_W-1:0]  i_q;
  logic [IDX_W-1:0]  j;
  logic [6:0]        i_p1;
  logic [22:0]       prod;
  logic [VEC_W-1:0]  w_q;
  logic [VEC_W-1:0]  w_swap;
  logic              lfsr_load;

  function automatic logic [VEC_W-1:0] identity();
    logic [VEC_W-1:0] r;
    r = '0;
    for (int k = 0; k < N_TILES; k++) begin
      r[k*IDX_W +: IDX_W] = IDX_W'(k);
    end
    return r;
  endfunction

  assign lfsr_load = seed_load && (state == IDLE);

  lfsr16 #(
    .SEED_INIT(SEED_INIT)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .load_val(seed_in),
    .q       (lfsr_q)
  );

  // Scale the LFSR into 0..i by taking the top of lfsr*(i+1).
  assign i_p1 = 7'(i_q) + 7'd1;
  assign prod = 23'(lfsr_q) * 23'(i_p1);
  assign j    = IDX_W'(prod >> 16);

  always_comb begin
    w_swap = w_q;
    w_swap[i_q*IDX_W +: IDX_W] = w_q[j*IDX_W +: IDX_W];
    w_swap[j*IDX_W +: IDX_W]   = w_q[i_q*IDX_W +: IDX_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      order_valid <= 1'b0;
      order       <= identity();
      w_q         <= identity();
      i_q         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !seed_load) begin
            state <= INIT;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          w_q   <= identity();
          i_q   <= IDX_W'(N_TILES - 1);
          state <= SHUFFLE;
        end
        SHUFFLE: begin
          w_q <= w_swap;
          i_q <= i_q - IDX_W'(1);
          // Publish with the final swap so done and order align.
          if (i_q == IDX_W'(1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            order       <= w_swap;
            order_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
